// File: rtl/ddr_dimm_responder.sv
// ddr_dimm_responder
//   DIMM-side model that answers a DDR controller's command stream.
//   Tracks which row is open in each bank, holds the device busy for
//   tRCD after ACT and tRP after PRE, and runs BL8/BC4 read and write
//   bursts against an internal word array after CL/CWL cycles of latency.
//
// Ports
//   clock, reset          system clock, synchronous active-high reset
//   cmd_valid/cmd_type    command strobe and opcode (00 PRE, 01 ACT, 10 WR, 11 RD)
//   cmd_bank/row/col      command address fields
//   mrs_update/bl_update  mode-register burst-length update (10 = BC4, else BL8)
//   wr_data               write beat, sampled on each write-burst cycle
//   rd_data/rd_valid      read beat and its qualifier
//   dev_busy/next_cmd     command in progress / ready for a new command
//   dev_rd                read burst window
//   burst_len             current mode-register burst length (8 or 4)
//   cmd_err               one-cycle pulse for an illegal or ignored command
//
// Build option
//   RD_PREAMBLE_EN  when defined, dev_rd rises one cycle ahead of the first
//                   read beat to model the read preamble.

module ddr_dimm_responder #(
  parameter int DATA_W = 64,
  parameter int BANK_W = 2,
  parameter int ROW_W  = 3,
  parameter int COL_W  = 5,
  parameter int T_RCD  = 4,
  parameter int T_RP   = 3,
  parameter int CL     = 5,
  parameter int CWL    = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cmd_valid,
  input  logic [1:0]        cmd_type,
  input  logic [BANK_W-1:0] cmd_bank,
  input  logic [ROW_W-1:0]  cmd_row,
  input  logic [COL_W-1:0]  cmd_col,
  input  logic              mrs_update,
  input  logic [1:0]        bl_update,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              dev_busy,
  output logic              next_cmd,
  output logic              dev_rd,
  output logic [3:0]        burst_len,
  output logic              cmd_err
);

  localparam int NBANK  = 1 << BANK_W;
  localparam int ADDR_W = BANK_W + ROW_W + COL_W;
  localparam int DEPTH  = 1 << ADDR_W;
  localparam int CNT_W  = 8;

  localparam logic [1:0] CMD_PRE = 2'b00;
  localparam logic [1:0] CMD_ACT = 2'b01;
  localparam logic [1:0] CMD_WR  = 2'b10;
  localparam logic [1:0] CMD_RD  = 2'b11;

  typedef enum logic [1:0] {IDLE, WAIT_T, LAT, BURST} state_t;

  state_t                   state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [3:0]               beat_q, beat_d;
  logic                     op_rd_q, op_rd_d;
  logic                     burst_bl8_q, burst_bl8_d;
  logic [BANK_W-1:0]        bank_q, bank_d;
  logic [ROW_W-1:0]         row_q, row_d;
  logic [COL_W-1:0]         col_q, col_d;
  logic [NBANK-1:0]         bank_open_q, bank_open_d;
  logic [NBANK-1:0][ROW_W-1:0] bank_row_q, bank_row_d;
  logic                     bl8_q, bl8_d;
  logic [DATA_W-1:0]        rd_data_q, rd_data_d;
  logic                     rd_valid_q, rd_valid_d;
  logic                     dev_rd_q, dev_rd_d;
  logic                     cmd_err_q, cmd_err_d;
  logic [ADDR_W-1:0]        rd_addr;
  logic [ADDR_W-1:0]        wr_addr;

  logic [DATA_W-1:0]        array_q [DEPTH];

  // Column of a given beat: the low 3 (BL8) or 2 (BC4) column bits count
  // up from the start column and wrap inside the aligned burst block.
  function automatic logic [COL_W-1:0] beat_col(input logic [COL_W-1:0] start,
                                                input logic bl8,
                                                input logic [3:0] beat);
    logic [COL_W-1:0] mask;
    logic [COL_W-1:0] step;
    mask = bl8 ? COL_W'(7) : COL_W'(3);
    step = start + COL_W'(beat);
    return (start & ~mask) | (step & mask);
  endfunction

  assign wr_addr = {bank_q, row_q, beat_col(col_q, burst_bl8_q, beat_q)};

  // Next-state logic: command decode in IDLE, countdowns in WAIT_T and LAT,
  // beat sequencing in BURST. The mode register is independent of the FSM
  // and a command accepted on the same edge captures the old value.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    beat_d      = beat_q;
    op_rd_d     = op_rd_q;
    burst_bl8_d = burst_bl8_q;
    bank_d      = bank_q;
    row_d       = row_q;
    col_d       = col_q;
    bank_open_d = bank_open_q;
    bank_row_d  = bank_row_q;
    bl8_d       = bl8_q;
    cmd_err_d   = 1'b0;
    rd_valid_d  = 1'b0;
    rd_data_d   = '0;
    dev_rd_d    = 1'b0;
    rd_addr     = '0;

    if (mrs_update) begin
      bl8_d = (bl_update != 2'b10);
    end

    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          case (cmd_type)
            CMD_PRE: begin
              bank_open_d[cmd_bank] = 1'b0;
              state_d = WAIT_T;
              cnt_d   = CNT_W'(T_RP - 1);
            end
            CMD_ACT: begin
              if (bank_open_q[cmd_bank]) begin
                cmd_err_d = 1'b1;
              end else begin
                bank_open_d[cmd_bank] = 1'b1;
                bank_row_d[cmd_bank]  = cmd_row;
                state_d = WAIT_T;
                cnt_d   = CNT_W'(T_RCD - 1);
              end
            end
            CMD_WR, CMD_RD: begin
              if (!bank_open_q[cmd_bank]) begin
                cmd_err_d = 1'b1;
              end else begin
                op_rd_d     = (cmd_type == CMD_RD);
                burst_bl8_d = bl8_q;
                bank_d      = cmd_bank;
                row_d       = bank_row_q[cmd_bank];
                col_d       = cmd_col;
                state_d     = LAT;
                cnt_d       = (cmd_type == CMD_RD) ? CNT_W'(CL - 1) : CNT_W'(CWL - 1);
              end
            end
            default: ;
          endcase
        end
      end
      WAIT_T: begin
        cmd_err_d = cmd_valid;
        if (cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      LAT: begin
        cmd_err_d = cmd_valid;
        if (cnt_q == '0) begin
          state_d = BURST;
          beat_d  = 4'd0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      BURST: begin
        cmd_err_d = cmd_valid;
        if (beat_q == (burst_bl8_q ? 4'd7 : 4'd3)) begin
          state_d = IDLE;
        end else begin
          beat_d = beat_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Read data is registered, so the word for the beat that starts at the
    // coming edge is fetched now using the next beat index.
    if (state_d == BURST && op_rd_d) begin
      rd_addr    = {bank_d, row_d, beat_col(col_d, burst_bl8_d, beat_d)};
      rd_valid_d = 1'b1;
      rd_data_d  = array_q[rd_addr];
    end

`ifdef RD_PREAMBLE_EN
    // The last latency cycle of a read opens the window one cycle early.
    dev_rd_d = rd_valid_d || (state_d == LAT && op_rd_d && cnt_d == '0);
`else
    dev_rd_d = rd_valid_d;
`endif
  end

  // State and output registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      beat_q      <= '0;
      op_rd_q     <= 1'b0;
      burst_bl8_q <= 1'b1;
      bank_q      <= '0;
      row_q       <= '0;
      col_q       <= '0;
      bank_open_q <= '0;
      bank_row_q  <= '0;
      bl8_q       <= 1'b1;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
      dev_rd_q    <= 1'b0;
      cmd_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      beat_q      <= beat_d;
      op_rd_q     <= op_rd_d;
      burst_bl8_q <= burst_bl8_d;
      bank_q      <= bank_d;
      row_q       <= row_d;
      col_q       <= col_d;
      bank_open_q <= bank_open_d;
      bank_row_q  <= bank_row_d;
      bl8_q       <= bl8_d;
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_valid_d;
      dev_rd_q    <= dev_rd_d;
      cmd_err_q   <= cmd_err_d;
    end
  end

  // Word array, not reset. A write beat lands at the end of its cycle; an
  // edge that sees reset drops the beat so an aborted burst stops writing.
  always_ff @(posedge clock) begin
    if (!reset && state_q == BURST && !op_rd_q) begin
      array_q[wr_addr] <= wr_data;
    end
  end

  assign rd_data   = rd_data_q;
  assign rd_valid  = rd_valid_q;
  assign dev_rd    = dev_rd_q;
  assign cmd_err   = cmd_err_q;
  assign dev_busy  = (state_q != IDLE);
  assign next_cmd  = (state_q == IDLE);
  assign burst_len = bl8_q ? 4'd8 : 4'd4;

endmodule

// File: tb/tb_ddr_dimm_responder.sv
// tb_ddr_dimm_responder
//   Self-checking bench for ddr_dimm_responder. Written words are kept in a
//   model array; each read pushes its expected beats onto a queue that a
//   negedge monitor pops whenever rd_valid is seen. Timing of busy, latency,
//   burst windows and error pulses is checked inline in each test task.

module tb_ddr_dimm_responder;

  localparam int DATA_W = 64;
  localparam int BANK_W = 2;
  localparam int ROW_W  = 3;
  localparam int COL_W  = 5;
  localparam int T_RCD  = 4;
  localparam int T_RP   = 3;
  localparam int CL     = 5;
  localparam int CWL    = 4;
`ifdef RD_PREAMBLE_EN
  localparam bit PREAMBLE = 1'b1;
`else
  localparam bit PREAMBLE = 1'b0;
`endif

  logic              clock;
  logic              reset;
  logic              cmd_valid;
  logic [1:0]        cmd_type;
  logic [BANK_W-1:0] cmd_bank;
  logic [ROW_W-1:0]  cmd_row;
  logic [COL_W-1:0]  cmd_col;
  logic              mrs_update;
  logic [1:0]        bl_update;
  logic [DATA_W-1:0] wr_data;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              dev_busy;
  logic              next_cmd;
  logic              dev_rd;
  logic [3:0]        burst_len;
  logic              cmd_err;

  int n_checks = 0;
  int n_fail   = 0;

  logic [DATA_W-1:0] model_mem [int];
  int                row_of [4];
  logic [DATA_W-1:0] exp_q [$];

  ddr_dimm_responder #(
    .DATA_W(DATA_W), .BANK_W(BANK_W), .ROW_W(ROW_W), .COL_W(COL_W),
    .T_RCD(T_RCD), .T_RP(T_RP), .CL(CL), .CWL(CWL)
  ) dut (
    .clock(clock), .reset(reset), .cmd_valid(cmd_valid), .cmd_type(cmd_type),
    .cmd_bank(cmd_bank), .cmd_row(cmd_row), .cmd_col(cmd_col),
    .mrs_update(mrs_update), .bl_update(bl_update), .wr_data(wr_data),
    .rd_data(rd_data), .rd_valid(rd_valid), .dev_busy(dev_busy),
    .next_cmd(next_cmd), .dev_rd(dev_rd), .burst_len(burst_len), .cmd_err(cmd_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  // Scoreboard: every read beat must match the oldest outstanding expectation.
  always @(negedge clock) begin
    if (rd_valid === 1'b1) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("[TB] FAIL rd_unexpected got data %h want no beat", rd_data);
      end else begin
        logic [DATA_W-1:0] e;
        e = exp_q.pop_front();
        if (rd_data !== e) begin
          n_fail++;
          $display("[TB] FAIL rd_data got %h want %h", rd_data, e);
        end
      end
    end
  end

  function automatic int word_addr(input int b, input int r, input int c);
    return (((b << ROW_W) | r) << COL_W) | c;
  endfunction

  // Column of beat i for a burst starting at col, wrapping in its aligned block.
  function automatic int beat_c(input int col, input int bl, input int i);
    int m;
    m = (bl == 8) ? 7 : 3;
    return (col & ~m) | ((col + i) & m);
  endfunction

  // Drives one command on the current negedge and releases it after the edge.
  task automatic issue(input logic [1:0] t, input int b, input int r, input int c);
    cmd_valid = 1'b1;
    cmd_type  = t;
    cmd_bank  = BANK_W'(b);
    cmd_row   = ROW_W'(r);
    cmd_col   = COL_W'(c);
    @(posedge clock);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic do_act(input int b, input int r);
    issue(2'b01, b, r, 0);
    row_of[b] = r;
    for (int j = 0; j < T_RCD; j++) begin
      @(negedge clock);
      n_checks++;
      if (dev_busy !== 1'b1 || next_cmd !== 1'b0) begin
        n_fail++;
        $display("[TB] FAIL act_busy j=%0d got busy=%b next=%b want 1/0", j, dev_busy, next_cmd);
      end
    end
    @(negedge clock);
    n_checks++;
    if (next_cmd !== 1'b1 || dev_busy !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL act_done got next=%b busy=%b want 1/0", next_cmd, dev_busy);
    end
  endtask

  task automatic do_pre(input int b);
    issue(2'b00, b, 0, 0);
    for (int j = 0; j < T_RP; j++) begin
      @(negedge clock);
      n_checks++;
      if (dev_busy !== 1'b1) begin
        n_fail++;
        $display("[TB] FAIL pre_busy j=%0d got %b want 1", j, dev_busy);
      end
    end
    @(negedge clock);
    n_checks++;
    if (next_cmd !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL pre_done got next=%b want 1", next_cmd);
    end
  endtask

  task automatic do_write(input int b, input int c, input int bl, input int base);
    issue(2'b10, b, 0, c);
    for (int j = 0; j < CWL + bl; j++) begin
      if (j >= CWL) wr_data = DATA_W'(base + j - CWL);
      @(negedge clock);
      n_checks++;
      if (dev_busy !== 1'b1) begin
        n_fail++;
        $display("[TB] FAIL wr_busy j=%0d got %b want 1", j, dev_busy);
      end
      @(posedge clock);
      #1;
    end
    for (int i = 0; i < bl; i++)
      model_mem[word_addr(b, row_of[b], beat_c(c, bl, i))] = DATA_W'(base + i);
    @(negedge clock);
    n_checks++;
    if (next_cmd !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL wr_done got next=%b want 1", next_cmd);
    end
  endtask

  // bl is the burst length the read is expected to run with; mrs_en drives
  // a burst-length update on the same edge as the command.
  task automatic do_read(input int b, input int c, input int bl,
                         input bit mrs_en, input logic [1:0] mrs_bl);
    for (int i = 0; i < bl; i++)
      exp_q.push_back(model_mem[word_addr(b, row_of[b], beat_c(c, bl, i))]);
    mrs_update = mrs_en;
    bl_update  = mrs_bl;
    issue(2'b11, b, 0, c);
    mrs_update = 1'b0;
    for (int j = 0; j < CL + bl; j++) begin
      bit ev;
      bit ed;
      ev = (j >= CL);
      ed = ev || (PREAMBLE && j == CL - 1);
      @(negedge clock);
      n_checks++;
      if (rd_valid !== ev || dev_busy !== 1'b1) begin
        n_fail++;
        $display("[TB] FAIL rd_window j=%0d got valid=%b busy=%b want %b/1", j, rd_valid, dev_busy, ev);
      end
      n_checks++;
      if (dev_rd !== ed) begin
        n_fail++;
        $display("[TB] FAIL dev_rd j=%0d got %b want %b", j, dev_rd, ed);
      end
      if (mrs_en && j == 0) begin
        n_checks++;
        if (burst_len !== ((mrs_bl == 2'b10) ? 4'd4 : 4'd8)) begin
          n_fail++;
          $display("[TB] FAIL mrs_same_edge got burst_len=%0d", burst_len);
        end
      end
    end
    @(negedge clock);
    n_checks++;
    if (next_cmd !== 1'b1 || dev_rd !== 1'b0 || rd_valid !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL rd_done got next=%b dev_rd=%b valid=%b want 1/0/0", next_cmd, dev_rd, rd_valid);
    end
  endtask

  task automatic expect_err(input logic [1:0] t, input int b, input int r, input int c);
    issue(t, b, r, c);
    @(negedge clock);
    n_checks++;
    if (cmd_err !== 1'b1 || next_cmd !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL err_pulse type=%b bank=%0d got err=%b next=%b want 1/1", t, b, cmd_err, next_cmd);
    end
    @(negedge clock);
    n_checks++;
    if (cmd_err !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL err_one_cycle got %b want 0", cmd_err);
    end
  endtask

  task automatic set_bl(input logic [1:0] v, input int want);
    mrs_update = 1'b1;
    bl_update  = v;
    @(posedge clock);
    #1 mrs_update = 1'b0;
    @(negedge clock);
    n_checks++;
    if (burst_len !== 4'(want)) begin
      n_fail++;
      $display("[TB] FAIL burst_len got %0d want %0d", burst_len, want);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    n_checks++;
    if (rd_data !== '0 || rd_valid !== 1'b0 || dev_busy !== 1'b0 || next_cmd !== 1'b1 ||
        dev_rd !== 1'b0 || burst_len !== 4'd8 || cmd_err !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL reset_values got data=%h v=%b busy=%b next=%b rd=%b bl=%0d err=%b",
               rd_data, rd_valid, dev_busy, next_cmd, dev_rd, burst_len, cmd_err);
    end
    reset = 1'b0;
  endtask

  task automatic test_act_wr_rd();
    do_act(1, 3);
    do_write(1, 'h08, 8, 'h11);
    do_read(1, 'h08, 8, 1'b0, 2'b00);
  endtask

  task automatic test_bl8_wrap();
    do_write(1, 'h08, 8, 'h108);
    do_read(1, 'h0D, 8, 1'b0, 2'b00);
  endtask

  task automatic test_bc4();
    set_bl(2'b10, 4);
    do_write(1, 'h04, 4, 'h204);
    do_read(1, 'h06, 4, 1'b0, 2'b00);
    do_read(1, 'h06, 4, 1'b1, 2'b00);
    do_read(1, 'h0A, 8, 1'b0, 2'b00);
  endtask

  task automatic test_errors();
    expect_err(2'b11, 2, 0, 0);
    expect_err(2'b01, 1, 6, 0);
    issue(2'b01, 0, 2, 0);
    row_of[0] = 2;
    @(negedge clock);
    cmd_valid = 1'b1;
    cmd_type  = 2'b01;
    cmd_bank  = 2'd2;
    cmd_row   = 3'd1;
    @(posedge clock);
    #1 cmd_valid = 1'b0;
    @(negedge clock);
    n_checks++;
    if (cmd_err !== 1'b1 || dev_busy !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL busy_cmd got err=%b busy=%b want 1/1", cmd_err, dev_busy);
    end
    repeat (T_RCD - 1) @(negedge clock);
    n_checks++;
    if (next_cmd !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL busy_cmd_done got next=%b want 1", next_cmd);
    end
    expect_err(2'b11, 2, 0, 0);
    do_read(1, 'h08, 8, 1'b0, 2'b00);
  endtask

  task automatic test_pre();
    do_pre(1);
    expect_err(2'b11, 1, 0, 'h08);
  endtask

  task automatic test_back_to_back();
    do_act(3, 5);
    do_write(3, 'h10, 8, 'h300);
    do_write(3, 'h10, 8, 'h400);
    do_read(3, 'h13, 8, 1'b0, 2'b00);
  endtask

  task automatic test_reset_mid_write();
    issue(2'b10, 3, 0, 'h10);
    for (int j = 0; j <= CWL + 2; j++) begin
      if (j >= CWL) wr_data = DATA_W'('h500 + j - CWL);
      @(negedge clock);
      if (j < CWL + 2) begin
        @(posedge clock);
        #1;
      end
    end
    reset = 1'b1;
    model_mem[word_addr(3, 5, 'h10)] = DATA_W'('h500);
    model_mem[word_addr(3, 5, 'h11)] = DATA_W'('h501);
    @(posedge clock);
    #1;
    @(negedge clock);
    n_checks++;
    if (next_cmd !== 1'b1 || dev_busy !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL wr_abort got next=%b busy=%b want 1/0", next_cmd, dev_busy);
    end
    reset = 1'b0;
    expect_err(2'b11, 0, 0, 0);
    do_act(3, 5);
    do_read(3, 'h10, 8, 1'b0, 2'b00);
  endtask

  task automatic test_reset_mid_read();
    set_bl(2'b10, 4);
    for (int i = 0; i < 4; i++)
      exp_q.push_back(model_mem[word_addr(3, 5, beat_c('h10, 4, i))]);
    issue(2'b11, 3, 0, 'h10);
    repeat (CL + 2) @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1 exp_q.delete();
    @(negedge clock);
    n_checks++;
    if (rd_valid !== 1'b0 || next_cmd !== 1'b1 || dev_rd !== 1'b0 || burst_len !== 4'd8) begin
      n_fail++;
      $display("[TB] FAIL rd_abort got valid=%b next=%b dev_rd=%b bl=%0d want 0/1/0/8",
               rd_valid, next_cmd, dev_rd, burst_len);
    end
    reset = 1'b0;
    expect_err(2'b11, 3, 0, 'h10);
  endtask

  initial begin
    reset      = 1'b1;
    cmd_valid  = 1'b0;
    cmd_type   = 2'b00;
    cmd_bank   = '0;
    cmd_row    = '0;
    cmd_col    = '0;
    mrs_update = 1'b0;
    bl_update  = 2'b00;
    wr_data    = '0;
    test_reset();
    test_act_wr_rd();
    test_bl8_wrap();
    test_bc4();
    test_errors();
    test_pre();
    test_back_to_back();
    test_reset_mid_write();
    test_reset_mid_read();
    @(negedge clock);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("[TB] FAIL scoreboard_drain got %0d pending want 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
